mul16_seq: RTL and testbench

MUL16_SEQ -- requirements
Module: mul16_seq

---
 rtl/mul_pkg.sv | 31 +++
 rtl/dadda_8.sv | 38 +++
 rtl/mul16_seq.sv | 120 ++++++++++++
 tb/tb_mul16_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the sequential 16x16 multiplier.
//   state_t    : controller states (IDLE, MUL, DONE)
//   OP_W       : operand width (16)
//   STEP_W     : width of one partial-multiply operand (8)
//   PROD_W     : product / accumulator width (32)
//   step_shift : left shift that places the result of a given 8x8 step
package mul_pkg;

    localparam int OP_W   = 16;
    localparam int STEP_W = 8;
    localparam int PROD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Steps 1 and 2 are the cross terms (lo*hi, hi*lo), both weighted by 2^8.
    function automatic logic [4:0] step_shift(input logic [1:0] step);
        logic [4:0] sh;
        unique case (step)
            2'd0:    sh = 5'd0;
            2'd1:    sh = 5'd8;
            2'd2:    sh = 5'd8;
            default: sh = 5'd16;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/dadda_8.sv
// Combinational 8x8 unsigned multiplier.
//   x : input  [7:0]  multiplicand
//   y : input  [7:0]  multiplier
//   p : output [15:0] x*y
// Partial-product rows are formed per multiplier bit and summed pairwise in a
// three-level tree; synthesis turns the row additions into its own compressor
// network, so the result is equivalent to a Dadda-style reduction.
module dadda_8
    import mul_pkg::*;
(
    input  logic [STEP_W-1:0]   x,
    input  logic [STEP_W-1:0]   y,
    output logic [2*STEP_W-1:0] p
);

    localparam int PW = 2 * STEP_W;

    logic [PW-1:0] pp [8];
    logic [PW-1:0] lvl1 [4];
    logic [PW-1:0] lvl2 [2];

    // Row gi is x weighted by 2^gi, present only when y[gi] is set.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_pp
            assign pp[gi] = y[gi] ? ({{STEP_W{1'b0}}, x} << gi) : {PW{1'b0}};
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_lvl1
            assign lvl1[gi] = pp[2*gi] + pp[2*gi+1];
        end
        for (genvar gi = 0; gi < 2; gi++) begin : g_lvl2
            assign lvl2[gi] = lvl1[2*gi] + lvl1[2*gi+1];
        end
    endgenerate

    // The full product of two 8-bit values always fits in 16 bits.
    assign p = lvl2[0] + lvl2[1];

endmodule

// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned multiplier built on one shared 8x8 multiplier.
// An accepted pair is multiplied in four cycles (one 8x8 step per cycle),
// accumulated into a 32-bit register, and presented with a valid/ready
// handshake. With EARLY_ZERO set, a zero operand skips the steps entirely.
//   clk       : input        rising-edge clock
//   rst_n     : input        asynchronous active-low reset
//   in_valid  : input        operand pair valid
//   in_ready  : output       pair can be accepted (IDLE only)
//   a, b      : input  [15:0] unsigned operands
//   out_valid : output       product valid (DONE only)
//   out_ready : input        consumer takes the product
//   product   : output [31:0] a*b, held while out_valid && !out_ready
//   busy      : output       high whenever not IDLE
module mul16_seq
    import mul_pkg::*;
#(
    parameter bit EARLY_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product,
    output logic              busy
);

    state_t              state_reg, state_next;
    logic [OP_W-1:0]     a_reg, b_reg;
    logic [PROD_W-1:0]   acc_reg;
    logic [1:0]          step_reg;

    logic                accept;
    logic                zero_pair;
    logic [STEP_W-1:0]   mul_x, mul_y;
    logic [2*STEP_W-1:0] mul_p;
    logic [PROD_W-1:0]   step_term;

    assign accept    = in_valid && (state_reg == IDLE);
    assign zero_pair = (a == '0) || (b == '0);

    // Step order: lo*lo, lo*hi, hi*lo, hi*hi (a halves on x, b halves on y).
    always_comb begin
        mul_x = step_reg[1] ? a_reg[OP_W-1:STEP_W] : a_reg[STEP_W-1:0];
        mul_y = step_reg[0] ? b_reg[OP_W-1:STEP_W] : b_reg[STEP_W-1:0];
    end

    dadda_8 u_mult (
        .x (mul_x),
        .y (mul_y),
        .p (mul_p)
    );

    assign step_term = PROD_W'(mul_p) << step_shift(step_reg);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        unique case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = (EARLY_ZERO && zero_pair) ? DONE : MUL;
                end
            end
            MUL: begin
                if (step_reg == 2'd3) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, accumulator and step counter. The counter wraps from
    // 3 back to 0 on the last step, so it already reads 0 in DONE and IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            acc_reg  <= '0;
            step_reg <= '0;
        end else if (accept) begin
            a_reg    <= a;
            b_reg    <= b;
            acc_reg  <= '0;
            step_reg <= '0;
        end else if (state_reg == MUL) begin
            acc_reg  <= acc_reg + step_term;
            step_reg <= step_reg + 2'd1;
        end
    end

    assign product = acc_reg;

endmodule

// File: tb/tb_mul16_seq.sv
// Directed and random checks for mul16_seq. Two instances share clock and
// reset: dut (EARLY_ZERO=1) carries most tests, dut_nz (EARLY_ZERO=0) is used
// for the zero-operand latency comparison.
module tb_mul16_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] product;
    logic        busy;

    logic        z_in_valid = 1'b0;
    logic        z_in_ready;
    logic [15:0] z_a = '0;
    logic [15:0] z_b = '0;
    logic        z_out_valid;
    logic        z_out_ready = 1'b1;
    logic [31:0] z_product;
    logic        z_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mul16_seq #(.EARLY_ZERO(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    mul16_seq #(.EARLY_ZERO(1'b0)) dut_nz (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (z_in_valid),
        .in_ready  (z_in_ready),
        .a         (z_a),
        .b         (z_b),
        .out_valid (z_out_valid),
        .out_ready (z_out_ready),
        .product   (z_product),
        .busy      (z_busy)
    );

    // Drive a pair for one edge (caller is at posedge+1 in IDLE), then scramble
    // the inputs so any late sampling of a/b shows up in the product.
    task automatic accept(input logic [15:0] ta, input logic [15:0] tb);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
    endtask

    // lat = index of the first rising edge that sees out_valid high, counting
    // the accept edge as 0. Bounded so a stuck DUT still reaches the summary.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (product !== 32'h0) begin bad++; $display("FAIL reset_product got=%h want=00000000", product); end
        rst_n = 1'b1;
    endtask

    task automatic test_max;
        int lat;
        out_ready = 1'b1;
        accept(16'hFFFF, 16'hFFFF);
        wait_out(lat);
        total++; if (lat != 5) begin bad++; $display("FAIL max_latency got=%0d want=5", lat); end
        total++; if (product !== 32'hFFFE0001) begin bad++; $display("FAIL max_product got=%h want=fffe0001", product); end
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL max_valid_one_cycle got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL max_back_idle got=%b want=1", in_ready); end
        $display("txn max: a=ffff b=ffff product=%h lat=%0d", 32'hFFFE0001, lat);
    endtask

    task automatic test_stall;
        int lat;
        out_ready = 1'b0;
        accept(16'h1234, 16'h5678);
        wait_out(lat);
        total++; if (lat != 5) begin bad++; $display("FAIL stall_latency got=%0d want=5", lat); end
        total++; if (product !== 32'h06260060) begin bad++; $display("FAIL stall_product got=%h want=06260060", product); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++; if (out_valid !== 1'b1 || product !== 32'h06260060) begin
                bad++; $display("FAIL stall_hold%0d valid=%b product=%h want valid=1 product=06260060", i, out_valid, product);
            end
            total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
                bad++; $display("FAIL stall_flags%0d in_ready=%b busy=%b want 0/1", i, in_ready, busy);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stall_release got=%b want=0", out_valid); end
        $display("txn stall: a=1234 b=5678 product=%h lat=%0d", 32'h06260060, lat);
    endtask

    task automatic test_early_zero;
        int lat;
        out_ready = 1'b1;
        accept(16'h0000, 16'hABCD);
        wait_out(lat);
        total++; if (lat != 1) begin bad++; $display("FAIL ez_latency got=%0d want=1", lat); end
        total++; if (product !== 32'h0) begin bad++; $display("FAIL ez_product got=%h want=00000000", product); end
        @(posedge clk); #1;
        $display("txn early_zero: a=0000 b=abcd product=0 lat=%0d", lat);

        z_a = 16'h0000;
        z_b = 16'hABCD;
        z_in_valid = 1'b1;
        @(posedge clk); #1;
        z_in_valid = 1'b0;
        lat = 1;
        while (!z_out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        total++; if (lat != 5) begin bad++; $display("FAIL noez_latency got=%0d want=5", lat); end
        total++; if (z_product !== 32'h0) begin bad++; $display("FAIL noez_product got=%h want=00000000", z_product); end
        @(posedge clk); #1;
        $display("txn no_early_zero: a=0000 b=abcd product=0 lat=%0d", lat);
    endtask

    task automatic test_reset_mid;
        int lat;
        int seen;
        out_ready = 1'b1;
        accept(16'h00FF, 16'h0100);
        // Two more edges: steps 0 and 1 done, step 2 now in progress.
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        total++; if (in_ready !== 1'b1 || busy !== 1'b0 || product !== 32'h0) begin
            bad++; $display("FAIL midrst_state in_ready=%b busy=%b product=%h want 1/0/0", in_ready, busy, product);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (out_valid) seen++;
            @(posedge clk); #1;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midrst_no_valid got=%0d cycles want=0", seen); end
        accept(16'h0003, 16'h0005);
        wait_out(lat);
        total++; if (lat != 5 || product !== 32'h0000000F) begin
            bad++; $display("FAIL midrst_next lat=%0d product=%h want 5 0000000f", lat, product);
        end
        @(posedge clk); #1;
        $display("txn reset_mid: a=0003 b=0005 product=%h lat=%0d", product, lat);
    endtask

    task automatic test_back_to_back;
        int lat;
        out_ready = 1'b1;
        a = 16'h0001;
        b = 16'h0001;
        in_valid = 1'b1;
        @(posedge clk); #1;
        // Second pair presented during the first multiply; must not leak in.
        a = 16'h8000;
        b = 16'h0002;
        wait_out(lat);
        total++; if (lat != 5 || product !== 32'h00000001) begin
            bad++; $display("FAIL b2b_first lat=%0d product=%h want 5 00000001", lat, product);
        end
        @(posedge clk); #1;   // handshake edge
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_idle got=%b want=1", in_ready); end
        @(posedge clk); #1;   // second accept edge
        in_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b want=1", busy); end
        wait_out(lat);
        total++; if (lat != 5 || product !== 32'h00010000) begin
            bad++; $display("FAIL b2b_second lat=%0d product=%h want 5 00010000", lat, product);
        end
        @(posedge clk); #1;
        $display("txn back_to_back: products 00000001 then %h", product);
    endtask

    task automatic test_random;
        logic [15:0] ra, rb;
        logic [31:0] exp_p;
        int guard;
        int errs;
        errs = 0;
        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            exp_p = 32'(ra) * 32'(rb);
            out_ready = 1'($urandom_range(0, 1));
            accept(ra, rb);
            guard = 0;
            while (!(out_valid && out_ready) && guard < 60) begin
                @(posedge clk); #1;
                out_ready = 1'($urandom_range(0, 1));
                guard++;
            end
            total++;
            if (!out_valid || product !== exp_p) begin
                bad++; errs++;
                $display("FAIL rand%0d a=%h b=%h valid=%b got=%h want=%h", n, ra, rb, out_valid, product, exp_p);
            end
            @(posedge clk); #1;
        end
        $display("txn random: 1000 pairs, %0d wrong", errs);
    endtask

    initial begin
        test_reset();
        test_max();
        test_stall();
        test_early_zero();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
